// File: rtl/tmr_mult_pkg.sv
// tmr_mult_pkg: default geometry and saturation constant shared by the
// triple-redundant sign-magnitude multiplier.
`default_nettype none

package tmr_mult_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_INT_BITS  = 6;
  localparam int DEF_FRAC_BITS = 10;
  localparam int DEF_STAGES    = 2;
  localparam int DEF_CNT_W     = 8;

  // Largest magnitude representable in a default-width word.
  localparam logic [DEF_WIDTH-2:0] DEF_MAX_MAG = {(DEF_WIDTH-1){1'b1}};

endpackage

`default_nettype wire

// File: rtl/sm_mult_core.sv
// sm_mult_core: one pipelined sign-magnitude fixed-point multiplier replica
// with saturation, +0 normalisation and an LSB fault-injection hook.
`default_nettype none

module sm_mult_core
  import tmr_mult_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int STAGES    = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             fault,
  output logic [WIDTH:0]   q
);

  localparam int MW = WIDTH - 1;
  localparam int PW = 2 * MW;
  localparam logic [MW-1:0] MAX_MAG = {MW{1'b1}};

  logic [MW-1:0]              mag_a;
  logic [MW-1:0]              mag_b;
  logic [PW-1:0]              prod;
  logic [PW-1:0]              shifted;
  logic                       ovf_c;
  logic [MW-1:0]              mag_c;
  logic                       sign_c;
  logic [WIDTH-1:0]           res_c;
  logic [STAGES-1:0][WIDTH:0] stage_q;
  logic [STAGES-1:0][WIDTH:0] stage_d;

  always_comb begin
    mag_a   = a[MW-1:0];
    mag_b   = b[MW-1:0];
    prod    = PW'(mag_a) * PW'(mag_b);
    shifted = prod >> FRAC_BITS;
    ovf_c   = shifted > PW'(MAX_MAG);
    mag_c   = ovf_c ? MAX_MAG : shifted[MW-1:0];
    // Sign is dropped on a zero magnitude so -0 never leaves the core.
    sign_c  = (a[WIDTH-1] ^ b[WIDTH-1]) && (mag_c != '0);
    res_c   = {sign_c, mag_c};
    res_c[0] = res_c[0] ^ fault;

    stage_d = stage_q;
    if (en) begin
      stage_d[0] = {ovf_c, res_c};
      for (int i = 1; i < STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/tmr_pipe_multiplier.sv
// tmr_pipe_multiplier: three lockstep multiplier replicas behind a valid/ready
// pipeline, with bitwise majority voting and a saturating disagreement counter.
`default_nettype none

module tmr_pipe_multiplier
  import tmr_mult_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int INT_BITS  = DEF_INT_BITS,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int STAGES    = DEF_STAGES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       fault_inj,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             invalid,
  output logic [CNT_W-1:0] err_cnt
);

  if (WIDTH != INT_BITS + FRAC_BITS) begin : g_bad_width
    $error("tmr_pipe_multiplier: WIDTH must equal INT_BITS + FRAC_BITS");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("tmr_pipe_multiplier: STAGES must be within 1..4");
  end

  logic                   advance;
  logic [STAGES-1:0]      valid_q;
  logic [STAGES-1:0]      valid_d;
  logic [CNT_W-1:0]       err_cnt_q;
  logic [CNT_W-1:0]       err_cnt_d;
  logic [2:0][WIDTH:0]    rep_q;
  logic [WIDTH:0]         voted;
  logic                   disagree;

  // A held output freezes the whole pipe, bubbles included.
  assign out_valid = valid_q[STAGES-1];
  assign in_ready  = !(out_valid && !out_ready);
  assign advance   = in_ready;

  for (genvar i = 0; i < 3; i++) begin : g_replica
    sm_mult_core #(
      .WIDTH     (WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .STAGES    (STAGES)
    ) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .a     (a),
      .b     (b),
      .fault (fault_inj[i]),
      .q     (rep_q[i])
    );
  end

  always_comb begin
    voted    = (rep_q[0] & rep_q[1]) | (rep_q[0] & rep_q[2]) | (rep_q[1] & rep_q[2]);
    disagree = (rep_q[0] != rep_q[1]) || (rep_q[0] != rep_q[2]);

    valid_d = valid_q;
    if (advance) begin
      valid_d[0] = in_valid;
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
      end
    end

    err_cnt_d = err_cnt_q;
    if (out_valid && out_ready && disagree && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign result  = voted[WIDTH-1:0];
  assign ovf     = voted[WIDTH];
  assign invalid = disagree;
  assign err_cnt = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_tmr_pipe_multiplier.sv
// tb_tmr_pipe_multiplier: directed-vector bench for the voted multiplier.
`default_nettype none

module tb_tmr_pipe_multiplier;

  localparam int WIDTH  = 16;
  localparam int STAGES = 2;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       fault_inj;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             invalid;
  logic [CNT_W-1:0] err_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int exp_err     = 0;

  tmr_pipe_multiplier #(
    .WIDTH     (WIDTH),
    .INT_BITS  (6),
    .FRAC_BITS (10),
    .STAGES    (STAGES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .fault_inj (fault_inj),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .invalid   (invalid),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Present one operand pair for exactly one accepting edge; returns 1ns after it.
  task automatic push(input logic [15:0] va, input logic [15:0] vb, input logic [2:0] f);
    a = va; b = vb; fault_inj = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; fault_inj = 3'b000;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result: got %h want 0000", result); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    vectors++; if (invalid !== 1'b0) begin miscompares++; $display("FAIL reset_invalid: got %b want 0", invalid); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    push(16'h040A, 16'h0600, 3'b000);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early: out_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_latency: out_valid got %b want 1", out_valid); end
    vectors++; if (result !== 16'h060F) begin miscompares++; $display("FAIL basic_result: got %h want 060f", result); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL basic_ovf: got %b want 0", ovf); end
    vectors++; if (invalid !== 1'b0) begin miscompares++; $display("FAIL basic_invalid: got %b want 0", invalid); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_single: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_sign;
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic [15:0] te [3];
    ta = '{16'h0866, 16'h840A, 16'h0066};
    tb = '{16'h8600, 16'h8600, 16'h000A};
    te = '{16'h8C99, 16'h060F, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      push(ta[i], tb[i], 3'b000);
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b1 || result !== te[i]) begin miscompares++; $display("FAIL sign_%0d: valid %b result %h want 1 %h", i, out_valid, result, te[i]); end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL sign_ovf_%0d: got %b want 0", i, ovf); end
    end
  endtask

  task automatic test_saturate;
    logic [15:0] ta [2];
    logic [15:0] te [2];
    ta = '{16'h7C00, 16'hFC00};
    te = '{16'h7FFF, 16'hFFFF};
    for (int i = 0; i < 2; i++) begin
      push(ta[i], 16'h0800, 3'b000);
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b1 || result !== te[i]) begin miscompares++; $display("FAIL sat_%0d: valid %b result %h want 1 %h", i, out_valid, result, te[i]); end
      vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL sat_ovf_%0d: got %b want 1", i, ovf); end
      vectors++; if (invalid !== 1'b0) begin miscompares++; $display("FAIL sat_invalid_%0d: got %b want 0", i, invalid); end
    end
  endtask

  task automatic test_fault;
    logic [2:0]  tf [2];
    logic [15:0] te [2];
    tf = '{3'b001, 3'b011};
    te = '{16'h060F, 16'h060E};
    for (int i = 0; i < 2; i++) begin
      push(16'h040A, 16'h0600, tf[i]);
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b1 || result !== te[i]) begin miscompares++; $display("FAIL fault_result_%0d: valid %b result %h want 1 %h", i, out_valid, result, te[i]); end
      vectors++; if (invalid !== 1'b1) begin miscompares++; $display("FAIL fault_invalid_%0d: got %b want 1", i, invalid); end
      @(posedge clk); #1;
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      vectors++; if (err_cnt !== 8'(exp_err)) begin miscompares++; $display("FAIL fault_err_cnt_%0d: got %0d want %0d", i, err_cnt, exp_err); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] bv [8];
    logic [15:0] held;
    logic        stalled_prev;
    int          tx;
    int          rx;
    bv = '{16'h0100, 16'h8111, 16'h0222, 16'h8333, 16'h0444, 16'h8555, 16'h0666, 16'h8777};
    tx = 0; rx = 0; stalled_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (tx < 8) begin
        in_valid = 1'b1; a = 16'h0400; b = bv[tx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled_prev) begin
        vectors++; if (result !== held) begin miscompares++; $display("FAIL b2b_hold: result %h want %h", result, held); end
      end
      if (out_valid && !out_ready) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_in_ready: got %b want 0", in_ready); end
        held = result; stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (result !== bv[rx]) begin miscompares++; $display("FAIL b2b_result_%0d: got %h want %h", rx, result, bv[rx]); end
        rx++;
      end
      if (in_valid && in_ready) tx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++; if (rx != 8) begin miscompares++; $display("FAIL b2b_count: got %0d results want 8", rx); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_extra_%0d: out_valid got %b want 0", i, out_valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_err_saturation;
    a = 16'h040A; b = 16'h0600; fault_inj = 3'b001; in_valid = 1'b1; out_ready = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0; fault_inj = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
    vectors++; if (err_cnt !== 8'(exp_err)) begin miscompares++; $display("FAIL err_sat: got %0d want %0d", err_cnt, exp_err); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL err_sat_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight;
    a = 16'h040A; b = 16'h0600; fault_inj = 3'b001; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0; fault_inj = 3'b000; rst_n = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_err = 0;
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL midrst_err_cnt: got %0d want 0", err_cnt); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_ghost_%0d: out_valid got %b want 0", i, out_valid); end
      @(posedge clk); #1;
    end
    push(16'h040A, 16'h0600, 3'b000);
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1 || result !== 16'h060F) begin miscompares++; $display("FAIL midrst_recover: valid %b result %h want 1 060f", out_valid, result); end
    @(posedge clk); #1;
    vectors++; if (err_cnt !== 8'(exp_err)) begin miscompares++; $display("FAIL midrst_err_after: got %0d want %0d", err_cnt, exp_err); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; fault_inj = 3'b000; out_ready = 1'b1;
    test_reset;
    test_basic;
    test_sign;
    test_saturate;
    test_fault;
    test_back_to_back;
    test_err_saturation;
    test_reset_midflight;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tmr_pipe_multiplier.md
TMR_PIPE_MULTIPLIER -- requirements
Module: tmr_pipe_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16: total word width, sign-magnitude.
REQ-002 SHALL have parameter INT_BITS, default 6: integer bits including the sign bit.
REQ-003 SHALL have parameter FRAC_BITS, default 10: fraction bits; WIDTH == INT_BITS + FRAC_BITS, elaboration error otherwise.
REQ-004 SHALL have parameter STAGES, default 2: pipeline depth, legal range 1..4.
REQ-005 SHALL have parameter CNT_W, default 8: error-counter width.
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 in_valid  in  1  operand pair present.
REQ-009 in_ready  out  1  block accepts operands this cycle.
REQ-010 a, b  in  WIDTH each  operands, bit WIDTH-1 = sign, rest = magnitude.
REQ-011 fault_inj  in  3  per-replica LSB-flip fault injection (test hook).
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 result  out  WIDTH  voted product.
REQ-015 ovf  out  1  voted overflow flag, qualified by out_valid.
REQ-016 invalid  out  1  replicas disagreed on this result, qualified by out_valid.
REQ-017 err_cnt  out  CNT_W  saturating count of invalid results delivered.

Function
REQ-018 SHALL accept operands on a rising edge where in_valid && in_ready.
REQ-019 SHALL drive in_ready = !(out_valid && !out_ready); a stall freezes every stage.
REQ-020 SHALL present the result of an accepted pair exactly STAGES cycles after acceptance when no stall occurs; each stall cycle adds one cycle.
REQ-021 SHALL hold result, ovf and invalid stable while out_valid && !out_ready.
REQ-022 SHALL sustain one result per cycle when out_ready is held high.
REQ-023 SHALL compute three independent replicas, each: magnitude = (|a|*|b|) >> FRAC_BITS, truncated, with sign = sign(a) XOR sign(b).
REQ-024 SHALL set replica ovf when the shifted magnitude exceeds 2^(WIDTH-1)-1, saturating the magnitude to 2^(WIDTH-1)-1 with the computed sign.
REQ-025 SHALL force a zero magnitude to +0 (sign bit 0), including -0 operands.
REQ-026 SHALL XOR bit 0 of replica i result with fault_inj[i], sampled at acceptance, after saturation.
REQ-027 SHALL form result and ovf as a bitwise 2-of-3 majority of the three replicas.
REQ-028 SHALL assert invalid when any replica's {ovf, result} differs from any other.
REQ-029 SHALL increment err_cnt on each output transfer (out_valid && out_ready) with invalid=1, saturating at all-ones.
REQ-030 SHALL not issue extra or lost results: each accepted pair yields exactly one transfer, in order.

Reset
REQ-031 SHALL, on a clk edge with rst_n=0, clear all stage valids, out_valid, result, ovf, invalid and err_cnt to 0.
REQ-032 SHALL discard all in-flight operands on reset mid-operation; in_ready = 1 during and after reset.

Structure
REQ-033 SHALL place default WIDTH/INT_BITS/FRAC_BITS/STAGES values and the max-magnitude constant in package tmr_mult_pkg.
REQ-034 SHALL instantiate sub-module sm_mult_core (one pipelined sign-magnitude replica, with saturation and fault hook) three times; the voter and handshake stay in the top.

Verification
REQ-035 a=0x040A, b=0x0600, out_ready=1 -> result=0x060F, ovf=0, invalid=0, STAGES cycles later.
REQ-036 a=0x0866, b=0x8600 -> result=0x8C99; a=0x840A, b=0x8600 -> 0x060F; a=0x0066, b=0x000A -> 0x0000 (+0).
REQ-037 a=0x7C00, b=0x0800 -> result=0x7FFF, ovf=1; a=0xFC00, b=0x0800 -> result=0xFFFF, ovf=1.
REQ-038 a=0x040A, b=0x0600, fault_inj=3'b001 -> result=0x060F, invalid=1, err_cnt+1; fault_inj=3'b011 -> result=0x060E, invalid=1.
REQ-039 back-to-back 8 pairs, out_ready low for 3 cycles mid-stream -> in_ready low while stalled, all 8 results in order, none duplicated; err_cnt saturates at 255 after 300 faulted results.
REQ-040 rst_n low for 1 cycle with 2 pairs in flight -> no out_valid afterwards until new input, err_cnt=0.
